map_table_ckpt: RTL and testbench

MAP_TABLE_CKPT -- requirements
Module: map_table_ckpt

---
 rtl/map_table_ckpt_if.sv | 45 ++++
 rtl/map_table_ckpt.sv | 188 ++++++++++++++++++
 tb/tb_map_table_ckpt.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_table_ckpt_if.sv
// Rename-map bus bundle for map_table_ckpt.
// The master side is the rename/commit logic; the slave side is the map table.
//   clear_entries      : per-register "value is back in the architectural file"
//   dest_in / tag_in   : per-way destination register and new producer tag
//   rega_in / regb_in  : per-way source registers to look up
//   taga_out/tagb_out  : per-way producer tags for those sources
//   cdb_tag_in         : completed-result broadcast tags
//   ckpt_*             : checkpoint take / restore / release and status
interface map_table_ckpt_if #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 8,
  parameter int WAYS     = 2,
  parameter int NCDB     = 2,
  parameter int NCKPT    = 4
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NCKPT);

  logic [NUM_REGS-1:0]   clear_entries;
  logic [WAYS*RW-1:0]    dest_in;
  logic [WAYS*TAG_W-1:0] tag_in;
  logic [WAYS*RW-1:0]    rega_in;
  logic [WAYS*RW-1:0]    regb_in;
  logic [WAYS*TAG_W-1:0] taga_out;
  logic [WAYS*TAG_W-1:0] tagb_out;
  logic [NCDB*TAG_W-1:0] cdb_tag_in;
  logic                  ckpt_take;
  logic [CW-1:0]         ckpt_id_out;
  logic                  ckpt_full;
  logic                  ckpt_restore;
  logic [CW-1:0]         ckpt_restore_id;
  logic [NCKPT-1:0]      ckpt_release_mask;

  modport master (
    output clear_entries, dest_in, tag_in, rega_in, regb_in, cdb_tag_in,
           ckpt_take, ckpt_restore, ckpt_restore_id, ckpt_release_mask,
    input  taga_out, tagb_out, ckpt_id_out, ckpt_full
  );

  modport slave (
    input  clear_entries, dest_in, tag_in, rega_in, regb_in, cdb_tag_in,
           ckpt_take, ckpt_restore, ckpt_restore_id, ckpt_release_mask,
    output taga_out, tagb_out, ckpt_id_out, ckpt_full
  );
endinterface

// File: rtl/map_table_ckpt.sv
// Register rename map table with checkpoint snapshots.
// Each architectural register maps to a producer tag (all-ones = value lives in
// the architectural register file). Bit TAG_W-2 of a stored tag is the
// "result ready in ROB" flag, set when a matching tag appears on the CDB.
// A checkpoint slot captures the table's next state and keeps tracking CDB
// wakeups so a restore brings back an up-to-date map.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (table null, all slots invalid)
//   bus   : map_table_ckpt_if.slave, see the interface for signal meaning
module map_table_ckpt #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 8,
  parameter int WAYS     = 2,
  parameter int NCDB     = 2,
  parameter int NCKPT    = 4
) (
  input logic             clock,
  input logic             reset,
  map_table_ckpt_if.slave bus
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NCKPT);

  localparam logic [TAG_W-1:0] NULL_TAG = '1;
  localparam logic [TAG_W-1:0] RDY_MASK = TAG_W'(1) << (TAG_W - 2);

  logic [TAG_W-1:0] table_q [NUM_REGS];
  logic [TAG_W-1:0] table_d [NUM_REGS];
  logic [TAG_W-1:0] snap_q  [NCKPT][NUM_REGS];
  logic [TAG_W-1:0] snap_d  [NCKPT][NUM_REGS];
  logic [NCKPT-1:0] valid_q;
  logic [NCKPT-1:0] valid_d;

  logic [NUM_REGS-1:0] wr_hit;
  logic [TAG_W-1:0]    wr_tag [NUM_REGS];

  logic             restore_fire;
  logic             take_fire;
  logic             full;
  logic [CW-1:0]    take_id;
  logic [NCKPT-1:0] restore_onehot;
  logic [NCKPT-1:0] take_onehot;

  // Sets the ready flag of an entry whose tag (ready flag ignored) is on any
  // CDB port. Null entries and idle CDB ports never match.
  function automatic logic [TAG_W-1:0] cdb_update(
    input logic [TAG_W-1:0]      entry,
    input logic [NCDB*TAG_W-1:0] cdb
  );
    logic [TAG_W-1:0] result;
    logic [TAG_W-1:0] ctag;
    result = entry;
    for (int c = 0; c < NCDB; c++) begin
      ctag = cdb[c*TAG_W +: TAG_W];
      if (ctag != NULL_TAG && entry != NULL_TAG &&
          (ctag & ~RDY_MASK) == (entry & ~RDY_MASK)) begin
        result = entry | RDY_MASK;
      end
    end
    return result;
  endfunction

  // Source lookups. An older way in the same group renaming the same register
  // overrides the table; a later (younger) older-way match replaces an earlier
  // one. Bypassed tags are never ready, and the CDB is not forwarded here.
  always_comb begin
    logic [RW-1:0]    src_a;
    logic [RW-1:0]    src_b;
    logic [RW-1:0]    dst;
    logic [TAG_W-1:0] wtag;
    logic [TAG_W-1:0] ta;
    logic [TAG_W-1:0] tb;
    bus.taga_out = '0;
    bus.tagb_out = '0;
    for (int k = 0; k < WAYS; k++) begin
      src_a = bus.rega_in[k*RW +: RW];
      src_b = bus.regb_in[k*RW +: RW];
      ta = table_q[src_a];
      tb = table_q[src_b];
      for (int j = 0; j < k; j++) begin
        dst  = bus.dest_in[j*RW +: RW];
        wtag = bus.tag_in[j*TAG_W +: TAG_W];
        if (wtag != NULL_TAG && dst == src_a) begin
          ta = wtag & ~RDY_MASK;
        end
        if (wtag != NULL_TAG && dst == src_b) begin
          tb = wtag & ~RDY_MASK;
        end
      end
      bus.taga_out[k*TAG_W +: TAG_W] = ta;
      bus.tagb_out[k*TAG_W +: TAG_W] = tb;
    end
  end

  // Per-register write decode; scanning ways oldest to youngest lets the
  // youngest non-null writer of a register win.
  always_comb begin
    logic [RW-1:0]    dst;
    logic [TAG_W-1:0] wtag;
    wr_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_tag[r] = NULL_TAG;
    end
    for (int w = 0; w < WAYS; w++) begin
      dst  = bus.dest_in[w*RW +: RW];
      wtag = bus.tag_in[w*TAG_W +: TAG_W];
      if (wtag != NULL_TAG) begin
        wr_hit[dst] = 1'b1;
        wr_tag[dst] = wtag & ~RDY_MASK;
      end
    end
  end

  // Slot allocation: lowest currently-invalid slot. Slots freed this cycle are
  // still valid now, so they are naturally excluded from this cycle's take.
  always_comb begin
    logic found;
    found   = 1'b0;
    take_id = '0;
    for (int i = 0; i < NCKPT; i++) begin
      if (!valid_q[i] && !found) begin
        take_id = CW'(i);
        found   = 1'b1;
      end
    end
  end

  assign full             = &valid_q;
  assign bus.ckpt_full    = full;
  assign bus.ckpt_id_out  = take_id;

  // A restore of an invalid slot does nothing, so writes, clears and takes
  // only yield to a restore that actually fires.
  assign restore_fire   = bus.ckpt_restore && valid_q[bus.ckpt_restore_id];
  assign take_fire      = bus.ckpt_take && !full && !restore_fire;
  assign restore_onehot = restore_fire ? (NCKPT'(1) << bus.ckpt_restore_id) : '0;
  assign take_onehot    = take_fire ? (NCKPT'(1) << take_id) : '0;

  // Live table next state: restore > write > clear > CDB wakeup.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (restore_fire) begin
        table_d[r] = cdb_update(snap_q[bus.ckpt_restore_id][r], bus.cdb_tag_in);
      end else if (wr_hit[r]) begin
        table_d[r] = wr_tag[r];
      end else if (bus.clear_entries[r]) begin
        table_d[r] = NULL_TAG;
      end else begin
        table_d[r] = cdb_update(table_q[r], bus.cdb_tag_in);
      end
    end
  end

  // Snapshots keep listening to the CDB; the slot being taken instead captures
  // the live table's next state so it already includes this cycle's updates.
  always_comb begin
    for (int i = 0; i < NCKPT; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (take_onehot[i]) begin
          snap_d[i][r] = table_d[r];
        end else begin
          snap_d[i][r] = cdb_update(snap_q[i][r], bus.cdb_tag_in);
        end
      end
    end
    valid_d = (valid_q & ~bus.ckpt_release_mask & ~restore_onehot) | take_onehot;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        table_q[r] <= NULL_TAG;
      end
      for (int i = 0; i < NCKPT; i++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          snap_q[i][r] <= NULL_TAG;
        end
      end
      valid_q <= '0;
    end else begin
      table_q <= table_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Self-checking bench for map_table_ckpt: directed scenarios with constant
// expectations, then randomized traffic checked against a behavioural model
// of the rename map and its checkpoints.
module tb_map_table_ckpt;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 8;
  localparam int WAYS     = 2;
  localparam int NCDB     = 2;
  localparam int NCKPT    = 4;

  logic clock;
  logic reset;

  map_table_ckpt_if #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .WAYS(WAYS),
                      .NCDB(NCDB), .NCKPT(NCKPT)) bus ();

  map_table_ckpt #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .WAYS(WAYS),
                   .NCDB(NCDB), .NCKPT(NCKPT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Stimulus held in plain variables so the model sees exactly what was driven.
  logic [7:0]  s_tag  [2];
  logic [4:0]  s_dest [2];
  logic [4:0]  s_rega [2];
  logic [4:0]  s_regb [2];
  logic [7:0]  s_cdb  [2];
  logic [31:0] s_clear;
  logic        s_take;
  logic        s_restore;
  logic [1:0]  s_rid;
  logic [3:0]  s_rel;

  // Reference model state.
  logic [7:0] m_table [32];
  logic [7:0] m_snap  [4][32];
  bit         m_valid [4];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.tag_in            = {s_tag[1], s_tag[0]};
    bus.dest_in           = {s_dest[1], s_dest[0]};
    bus.rega_in           = {s_rega[1], s_rega[0]};
    bus.regb_in           = {s_regb[1], s_regb[0]};
    bus.cdb_tag_in        = {s_cdb[1], s_cdb[0]};
    bus.clear_entries     = s_clear;
    bus.ckpt_take         = s_take;
    bus.ckpt_restore      = s_restore;
    bus.ckpt_restore_id   = s_rid;
    bus.ckpt_release_mask = s_rel;
  endtask

  task automatic idle();
    for (int w = 0; w < 2; w++) begin
      s_tag[w]  = 8'hFF;
      s_dest[w] = '0;
      s_rega[w] = '0;
      s_regb[w] = '0;
      s_cdb[w]  = 8'hFF;
    end
    s_clear   = '0;
    s_take    = 1'b0;
    s_restore = 1'b0;
    s_rid     = '0;
    s_rel     = '0;
    applyStimulus();
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_table[r] = 8'hFF;
      for (int i = 0; i < 4; i++) m_snap[i][r] = 8'hFF;
    end
    for (int i = 0; i < 4; i++) m_valid[i] = 0;
  endtask

  // A tag becomes ready when a live CDB port carries the same tag number.
  function automatic logic [7:0] m_wake(input logic [7:0] e);
    logic [7:0] res;
    res = e;
    if (e != 8'hFF) begin
      for (int c = 0; c < 2; c++) begin
        if (s_cdb[c] != 8'hFF && (s_cdb[c] | 8'h40) == (e | 8'h40)) res = e | 8'h40;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] m_read(input int k, input logic [4:0] src);
    logic [7:0] v;
    v = m_table[src];
    for (int j = 0; j < k; j++) begin
      if (s_tag[j] != 8'hFF && s_dest[j] == src) v = s_tag[j] & 8'hBF;
    end
    return v;
  endfunction

  function automatic int m_free_id();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit m_full();
    return m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3];
  endfunction

  // One clock edge worth of architectural behaviour, applied in rule order:
  // wakeups, then clears, then renames oldest to youngest.
  task automatic model_step();
    logic [7:0] nt [32];
    logic [7:0] ns [4][32];
    bit restoring;
    bit was_full;
    int tid;
    restoring = s_restore && m_valid[s_rid];
    was_full  = m_full();
    tid       = m_free_id();
    for (int r = 0; r < 32; r++) begin
      nt[r] = restoring ? m_wake(m_snap[s_rid][r]) : m_wake(m_table[r]);
    end
    if (!restoring) begin
      for (int r = 0; r < 32; r++) if (s_clear[r]) nt[r] = 8'hFF;
      for (int w = 0; w < 2; w++) if (s_tag[w] != 8'hFF) nt[s_dest[w]] = s_tag[w] & 8'hBF;
    end
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 32; r++) ns[i][r] = m_wake(m_snap[i][r]);
    for (int i = 0; i < 4; i++) if (s_rel[i]) m_valid[i] = 0;
    if (restoring) m_valid[s_rid] = 0;
    if (s_take && !was_full && !restoring) begin
      for (int r = 0; r < 32; r++) ns[tid][r] = nt[r];
      m_valid[tid] = 1;
    end
    for (int r = 0; r < 32; r++) begin
      m_table[r] = nt[r];
      for (int i = 0; i < 4; i++) m_snap[i][r] = ns[i][r];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    #1;
  endtask

  task automatic check_against_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, "_taga"}, 32'(bus.taga_out[k*8 +: 8]), 32'(m_read(k, s_rega[k])));
      checkOutput({tag, "_tagb"}, 32'(bus.tagb_out[k*8 +: 8]), 32'(m_read(k, s_regb[k])));
    end
    checkOutput({tag, "_id"},   32'(bus.ckpt_id_out), 32'(m_free_id()));
    checkOutput({tag, "_full"}, 32'(bus.ckpt_full),   32'(m_full()));
  endtask

  function automatic logic [7:0] rand_tag();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 3) return 8'hFF;
    if (sel < 9) return 8'($urandom_range(0, 15));
    return 8'($urandom);
  endfunction

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b0;
    model_reset();
    idle();
    #12;
    reset = 1'b1;
    #1;

    // Reset state: every register unmapped, no slots in use.
    for (int r = 0; r < 32; r++) begin
      s_rega[0] = 5'(r);
      s_regb[1] = 5'(r);
      applyStimulus();
      #1;
      checkOutput("rst_taga", 32'(bus.taga_out[7:0]), 32'h0FF);
      checkOutput("rst_tagb", 32'(bus.tagb_out[15:8]), 32'h0FF);
    end
    checkOutput("rst_full", 32'(bus.ckpt_full), 32'h0);
    checkOutput("rst_id", 32'(bus.ckpt_id_out), 32'h0);

    // Intra-group bypass, then the written value from the table.
    idle();
    s_dest[0] = 5'd4; s_tag[0] = 8'h0A; s_rega[1] = 5'd4;
    applyStimulus();
    #1;
    checkOutput("byp_way1", 32'(bus.taga_out[15:8]), 32'h0A);
    tick();
    idle();
    s_rega[0] = 5'd4;
    applyStimulus();
    #1;
    checkOutput("byp_table", 32'(bus.taga_out[7:0]), 32'h0A);

    // Same-destination writes: youngest non-null way wins.
    idle();
    s_dest[0] = 5'd4; s_tag[0] = 8'h01; s_dest[1] = 5'd4; s_tag[1] = 8'h03;
    applyStimulus();
    tick();
    idle(); s_rega[0] = 5'd4; applyStimulus(); #1;
    checkOutput("samedst_young", 32'(bus.taga_out[7:0]), 32'h03);
    s_dest[0] = 5'd4; s_tag[0] = 8'h05; s_dest[1] = 5'd4; s_tag[1] = 8'hFF;
    applyStimulus();
    tick();
    idle(); s_rega[0] = 5'd4; applyStimulus(); #1;
    checkOutput("samedst_null", 32'(bus.taga_out[7:0]), 32'h05);

    // CDB wakeup, persistence, and clear.
    idle();
    s_dest[0] = 5'd1; s_tag[0] = 8'h01; s_dest[1] = 5'd2; s_tag[1] = 8'h03;
    applyStimulus();
    tick();
    idle(); s_cdb[0] = 8'h01; s_cdb[1] = 8'h03; applyStimulus();
    tick();
    idle(); s_rega[0] = 5'd1; s_regb[0] = 5'd2; applyStimulus(); #1;
    checkOutput("cdb_r1", 32'(bus.taga_out[7:0]), 32'h41);
    checkOutput("cdb_r2", 32'(bus.tagb_out[7:0]), 32'h43);
    tick();
    checkOutput("cdb_keep_r1", 32'(bus.taga_out[7:0]), 32'h41);
    checkOutput("cdb_keep_r2", 32'(bus.tagb_out[7:0]), 32'h43);
    s_clear = 32'h6; applyStimulus();
    tick();
    s_clear = 32'h0; applyStimulus(); #1;
    checkOutput("clr_r1", 32'(bus.taga_out[7:0]), 32'hFF);
    checkOutput("clr_r2", 32'(bus.tagb_out[7:0]), 32'hFF);

    // Checkpoint, overwrite, wake the checkpointed tag, restore.
    idle(); s_dest[0] = 5'd4; s_tag[0] = 8'h0A; applyStimulus();
    tick();
    idle(); s_take = 1'b1; applyStimulus(); #1;
    checkOutput("ck_take_id", 32'(bus.ckpt_id_out), 32'h0);
    tick();
    idle(); s_dest[0] = 5'd4; s_tag[0] = 8'h0B; applyStimulus();
    tick();
    idle(); s_cdb[0] = 8'h0A; s_rega[0] = 5'd4; applyStimulus(); #1;
    checkOutput("ck_live", 32'(bus.taga_out[7:0]), 32'h0B);
    tick();
    idle(); s_restore = 1'b1; s_rid = 2'd0; applyStimulus();
    tick();
    idle(); s_rega[0] = 5'd4; applyStimulus(); #1;
    checkOutput("ck_restored", 32'(bus.taga_out[7:0]), 32'h4A);
    checkOutput("ck_freed_id", 32'(bus.ckpt_id_out), 32'h0);
    checkOutput("ck_freed_full", 32'(bus.ckpt_full), 32'h0);

    // Fill all slots, overflow, release one, re-take it.
    for (int n = 0; n < 4; n++) begin
      idle(); s_take = 1'b1; applyStimulus(); #1;
      checkOutput("fill_id", 32'(bus.ckpt_id_out), 32'(n));
      tick();
    end
    checkOutput("fill_full", 32'(bus.ckpt_full), 32'h1);
    tick();
    checkOutput("over_full", 32'(bus.ckpt_full), 32'h1);
    idle(); s_rel = 4'h2; applyStimulus();
    tick();
    idle(); applyStimulus(); #1;
    checkOutput("rel_id", 32'(bus.ckpt_id_out), 32'h1);
    checkOutput("rel_full", 32'(bus.ckpt_full), 32'h0);
    s_take = 1'b1; applyStimulus();
    tick();
    idle(); applyStimulus(); #1;
    checkOutput("retake_full", 32'(bus.ckpt_full), 32'h1);

    // Asynchronous reset mid-sequence; updates held off, bypass still live.
    s_dest[0] = 5'd4; s_tag[0] = 8'h0A; s_rega[1] = 5'd4; s_rega[0] = 5'd4;
    applyStimulus();
    reset = 1'b0;
    model_reset();
    #1;
    checkOutput("arst_full", 32'(bus.ckpt_full), 32'h0);
    checkOutput("arst_id", 32'(bus.ckpt_id_out), 32'h0);
    checkOutput("arst_r4", 32'(bus.taga_out[7:0]), 32'hFF);
    checkOutput("arst_byp", 32'(bus.taga_out[15:8]), 32'h0A);
    s_take = 1'b1; applyStimulus();
    tick();
    tick();
    checkOutput("arst_hold_r4", 32'(bus.taga_out[7:0]), 32'hFF);
    checkOutput("arst_hold_full", 32'(bus.ckpt_full), 32'h0);
    idle();
    #3;
    reset = 1'b1;
    #1;
    check_against_model("post_rst");

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      for (int w = 0; w < 2; w++) begin
        s_tag[w]  = rand_tag();
        s_dest[w] = rand_reg();
        s_rega[w] = rand_reg();
        s_regb[w] = rand_reg();
        s_cdb[w]  = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      end
      s_clear   = ($urandom_range(0, 4) == 0) ? ($urandom & $urandom) : 32'h0;
      s_take    = ($urandom_range(0, 2) == 0);
      s_restore = ($urandom_range(0, 7) == 0);
      s_rid     = 2'($urandom_range(0, 3));
      s_rel     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      applyStimulus();
      #1;
      check_against_model("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
